// File: rtl/palette_ctrl_if.sv
// Host-side bus of the palette controller: palette write port, fade control
// and flicker enable, plus the fade FSM state for observation.
//
// Write handshake: wr_en is the request and wr_ready is the acceptance
// condition. A write transfers on any rising clock edge where
// wr_en & wr_ready are both high. wr_en while wr_ready is low is ignored.
// wr_addr/wr_data only need to be valid in the transfer cycle.
interface palette_ctrl_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_ready;
    logic        fade_start;
    logic        fade_dir;
    logic        fade_busy;
    logic        fade_done;
    logic        flicker_en;
    logic [1:0]  fade_state;

    modport master (
        output wr_en, wr_addr, wr_data, fade_start, fade_dir, flicker_en,
        input  wr_ready, fade_busy, fade_done, fade_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, fade_start, fade_dir, flicker_en,
        output wr_ready, fade_busy, fade_done, fade_state
    );
endinterface

// File: rtl/palette_ctrl.sv
// Frame-synchronous 16-entry, 24-bit palette controller. Host writes are
// held in a one-deep buffer and committed only during vertical blank. The
// pixel path is one registered stage: lookup, optional candle flicker
// substitution (entry 8 -> entry 12) and global brightness scaling.
module palette_ctrl #(
    parameter int FRAME_DIV = 8,   // frames per flicker phase toggle, >= 1
    parameter int FADE_STEP = 1    // brightness change per frame, 1..16
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         frame_start,
    input  logic         vblank,
    input  logic [3:0]   colorIdx,
    output logic [7:0]   VGA_R,
    output logic [7:0]   VGA_G,
    output logic [7:0]   VGA_B,
    palette_ctrl_if.slave host
);

    localparam int          CW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [5:0]  STEP6 = 6'(FADE_STEP);
    localparam logic [4:0]  FULL  = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FADING = 2'd1,
        S_DONE   = 2'd2
    } fade_state_t;

    // Power-on palette contents.
    function automatic logic [23:0] default_entry(input logic [3:0] idx);
        logic [23:0] v;
        case (idx)
            4'd0:    v = 24'hFF0000;
            4'd1:    v = 24'h05121B;
            4'd2:    v = 24'h2D4745;
            4'd3:    v = 24'h46615B;
            4'd4:    v = 24'h082026;
            4'd5:    v = 24'h223A42;
            4'd6:    v = 24'h000000;
            4'd7:    v = 24'hBDBFA0;
            4'd8:    v = 24'hFE9802;
            4'd9:    v = 24'h9A9A9A;
            4'd10:   v = 24'h16252F;
            4'd11:   v = 24'hD624C1;
            4'd12:   v = 24'hFFFFFF;
            default: v = 24'hFF0000;
        endcase
        return v;
    endfunction

    // One channel scaled by level/16, truncated. 255*16 fits in 12 bits,
    // so bits [11:4] hold the whole result.
    function automatic logic [7:0] scale(input logic [7:0] ch, input logic [4:0] lvl);
        logic [12:0] prod;
        prod = {5'd0, ch} * {8'd0, lvl};
        return prod[11:4];
    endfunction

    logic [23:0]  pal [16];

    logic         buf_full;
    logic [3:0]   buf_addr;
    logic [23:0]  buf_data;
    logic         commit;

    logic [CW-1:0] frame_cnt;
    logic          phase;

    fade_state_t  state;
    logic [4:0]   level;
    logic         dir;
    logic         busy_q;
    logic         done_q;

    logic [5:0]   lvl_up_raw;
    logic [4:0]   lvl_up;
    logic [4:0]   lvl_dn;
    logic [4:0]   next_level;
    logic         next_at_target;
    logic         idle_at_target;

    logic [23:0]  base;

    // The buffer drains on the first blanking cycle it is full in.
    assign commit = buf_full & vblank;

    // Palette register file: reset to defaults, written only by a commit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 16; i++) begin
                pal[i] <= default_entry(4'(i));
            end
        end else if (commit) begin
            pal[buf_addr] <= buf_data;
        end
    end

    // One-deep host write buffer; accept and commit are mutually exclusive
    // because accepting requires the buffer to be empty.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            buf_full <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (commit) begin
            buf_full <= 1'b0;
        end else if (host.wr_en && !buf_full) begin
            buf_full <= 1'b1;
            buf_addr <= host.wr_addr;
            buf_data <= host.wr_data;
        end
    end

    assign host.wr_ready = ~buf_full;

    // Flicker frame counter and phase; runs whether or not flicker is on.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CW'(FRAME_DIV - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Next brightness level one step toward the latched target, saturating.
    always_comb begin
        lvl_up_raw = {1'b0, level} + STEP6;
        lvl_up     = (lvl_up_raw > 6'd16) ? FULL : lvl_up_raw[4:0];
        lvl_dn     = ({1'b0, level} > STEP6) ? (level - STEP6[4:0]) : 5'd0;
        next_level = dir ? lvl_up : lvl_dn;
        next_at_target = dir ? (next_level == FULL) : (next_level == 5'd0);
        idle_at_target = host.fade_dir ? (level == FULL) : (level == 5'd0);
    end

    // Fade FSM with registered busy/done; level persists between fades.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_IDLE;
            level  <= FULL;
            dir    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (host.fade_start) begin
                        dir    <= host.fade_dir;
                        busy_q <= 1'b1;
                        if (idle_at_target) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_FADING;
                        end
                    end
                end
                S_FADING: begin
                    if (frame_start) begin
                        level <= next_level;
                        if (next_at_target) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign host.fade_busy  = busy_q;
    assign host.fade_done  = done_q;
    assign host.fade_state = state;

    // Palette lookup with candle flicker substitution of entry 8.
    always_comb begin
        base = pal[colorIdx];
        if (host.flicker_en && phase && (colorIdx == 4'd8)) begin
            base = pal[12];
        end
    end

    // Registered, brightness-scaled pixel output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R <= 8'd0;
            VGA_G <= 8'd0;
            VGA_B <= 8'd0;
        end else begin
            VGA_R <= scale(base[23:16], level);
            VGA_G <= scale(base[15:8],  level);
            VGA_B <= scale(base[7:0],   level);
        end
    end

endmodule

// File: tb/tb_palette_ctrl.sv
// Self-checking bench for palette_ctrl: directed scenarios with literal
// expectations plus a randomized run, all cross-checked every cycle
// against a behavioural model of the palette, fade and flicker rules.
module tb_palette_ctrl;

    localparam int FRAME_DIV = 2;
    localparam int FADE_STEP = 1;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        vblank;
    logic [3:0]  color_idx;
    logic [7:0]  vga_r, vga_g, vga_b;

    palette_ctrl_if bus();

    palette_ctrl #(
        .FRAME_DIV(FRAME_DIV),
        .FADE_STEP(FADE_STEP)
    ) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .frame_start(frame_start),
        .vblank     (vblank),
        .colorIdx   (color_idx),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .host       (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [23:0] def_tab [16] = '{
        24'hFF0000, 24'h05121B, 24'h2D4745, 24'h46615B,
        24'h082026, 24'h223A42, 24'h000000, 24'hBDBFA0,
        24'hFE9802, 24'h9A9A9A, 24'h16252F, 24'hD624C1,
        24'hFFFFFF, 24'hFF0000, 24'hFF0000, 24'hFF0000
    };

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] m_pal [16];
    int          m_level;
    int          m_frames;
    bit          m_fading, m_done, m_dir;
    bit          m_full;
    logic [3:0]  m_addr;
    logic [23:0] m_data;
    bit          exp_ready, exp_busy, exp_done;
    logic [23:0] exp_q [$];

    function automatic logic [7:0] sc(input logic [7:0] c, input int lvl);
        return 8'((int'(c) * lvl) / 16);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = def_tab[i];
        m_level  = 16;
        m_frames = 0;
        m_fading = 0;
        m_done   = 0;
        m_dir    = 0;
        m_full   = 0;
        exp_ready = 1;
        exp_busy  = 0;
        exp_done  = 0;
        exp_q.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        logic [23:0] b;
        int          tgt;
        if (!rst_n) begin
            m_reset();
            exp_q.push_back(24'h0);
        end else begin
            // pixel seen on the outputs after this edge uses pre-edge state
            b = m_pal[color_idx];
            if (bus.flicker_en && ((m_frames / FRAME_DIV) % 2 == 1) && color_idx == 4'd8)
                b = m_pal[12];
            exp_q.push_back({sc(b[23:16], m_level), sc(b[15:8], m_level), sc(b[7:0], m_level)});
            // fade
            if (m_done) begin
                m_done = 0;
            end else if (m_fading) begin
                if (frame_start) begin
                    tgt = m_dir ? 16 : 0;
                    m_level = m_dir ? ((m_level + FADE_STEP > 16) ? 16 : m_level + FADE_STEP)
                                    : ((m_level - FADE_STEP < 0) ? 0 : m_level - FADE_STEP);
                    if (m_level == tgt) begin
                        m_fading = 0;
                        m_done   = 1;
                    end
                end
            end else if (bus.fade_start) begin
                m_dir = bus.fade_dir;
                if (m_level == (m_dir ? 16 : 0)) m_done = 1;
                else m_fading = 1;
            end
            if (frame_start) m_frames++;
            // write buffer
            if (m_full && vblank) begin
                m_pal[m_addr] = m_data;
                m_full = 0;
            end else if (!m_full && bus.wr_en) begin
                m_full = 1;
                m_addr = bus.wr_addr;
                m_data = bus.wr_data;
            end
            exp_ready = !m_full;
            exp_busy  = m_fading | m_done;
            exp_done  = m_done;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            chk("sb_vga", {vga_r, vga_g, vga_b}, exp_q.pop_front());
        end
        chk("sb_ready", bus.wr_ready, exp_ready);
        chk("sb_busy",  bus.fade_busy, exp_busy);
        chk("sb_done",  bus.fade_done, exp_done);
        if (bus.fade_done === 1'b1) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [23:0] flk_tab [6] = '{24'hFE9802, 24'hFFFFFF, 24'hFFFFFF,
                                 24'hFE9802, 24'hFE9802, 24'hFFFFFF};

    // ---------------- main sequence ----------------
    initial begin
        m_reset();
        rst_n = 1'b0;
        frame_start = 0; vblank = 0; color_idx = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.fade_start = 0; bus.fade_dir = 0; bus.flicker_en = 0;
        repeat (3) tick();
        chk("rst_vga",   {vga_r, vga_g, vga_b}, 24'h0);
        chk("rst_ready", bus.wr_ready, 1'b1);
        chk("rst_busy",  bus.fade_busy, 1'b0);
        chk("rst_done",  bus.fade_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // default table sweep
        for (int i = 0; i < 16; i++) begin
            color_idx = 4'(i);
            tick();
            chk("sweep", {vga_r, vga_g, vga_b}, def_tab[i]);
            if (i == 11) chk("idx11", {vga_r, vga_g, vga_b}, 24'hD624C1);
            if (i == 13) chk("idx13", {vga_r, vga_g, vga_b}, 24'hFF0000);
        end

        // buffered write, committed in vblank
        bus.wr_addr = 4'd2; bus.wr_data = 24'h123456; bus.wr_en = 1;
        tick();
        bus.wr_en = 0; color_idx = 4'd2;
        tick();
        chk("wr_pend_ready", bus.wr_ready, 1'b0);
        chk("wr_pend_old",   {vga_r, vga_g, vga_b}, 24'h2D4745);
        bus.wr_addr = 4'd5; bus.wr_data = 24'hAAAAAA; bus.wr_en = 1;
        tick();
        bus.wr_en = 0;
        tick();
        chk("wr_ignored_ready", bus.wr_ready, 1'b0);
        vblank = 1;
        tick();
        vblank = 0;
        chk("wr_commit_ready", bus.wr_ready, 1'b1);
        tick();
        chk("wr_new", {vga_r, vga_g, vga_b}, 24'h123456);
        color_idx = 4'd5;
        tick();
        chk("wr_ignored_data", {vga_r, vga_g, vga_b}, 24'h223A42);

        // fade out
        color_idx = 4'd12; bus.fade_dir = 0; bus.fade_start = 1;
        tick();
        bus.fade_start = 0;
        chk("fade_busy", bus.fade_busy, 1'b1);
        repeat (8) frame_pulse();
        chk("fade_half", {vga_r, vga_g, vga_b}, 24'h7F7F7F);
        bus.fade_dir = 1; bus.fade_start = 1;
        tick();
        bus.fade_start = 0;
        repeat (7) frame_pulse();
        chk("fade_lvl1", {vga_r, vga_g, vga_b}, 24'h0F0F0F);
        chk("fade_no_done_yet", 32'(done_cnt), 32'd0);
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("fade_done_pulse", bus.fade_done, 1'b1);
        tick();
        chk("fade_done_drop", bus.fade_done, 1'b0);
        chk("fade_idle", bus.fade_busy, 1'b0);
        tick();
        chk("fade_black", {vga_r, vga_g, vga_b}, 24'h000000);
        chk("fade_done_once", 32'(done_cnt), 32'd1);

        // fade back in, bounded wait
        bus.fade_dir = 1; bus.fade_start = 1;
        tick();
        bus.fade_start = 0;
        for (int f = 0; f < 40 && done_cnt < 2; f++) frame_pulse();
        chk("fadein_done", 32'(done_cnt), 32'd2);
        chk("fadein_full", {vga_r, vga_g, vga_b}, 24'hFFFFFF);

        // fade in while already at full
        bus.fade_start = 1;
        tick();
        bus.fade_start = 0;
        chk("noop_done", bus.fade_done, 1'b1);
        chk("noop_busy", bus.fade_busy, 1'b1);
        tick();
        chk("noop_done_drop", bus.fade_done, 1'b0);

        // flicker
        pulse_reset();
        color_idx = 4'd8; bus.flicker_en = 1;
        tick();
        chk("flk0", {vga_r, vga_g, vga_b}, 24'hFE9802);
        for (int f = 0; f < 6; f++) begin
            frame_pulse();
            chk("flk", {vga_r, vga_g, vga_b}, flk_tab[f]);
        end
        bus.flicker_en = 0;
        tick();
        chk("flk_off", {vga_r, vga_g, vga_b}, 24'hFE9802);

        // randomized run
        for (int c = 0; c < 3000; c++) begin
            frame_start    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) vblank = ~vblank;
            color_idx      = 4'($urandom_range(0, 15));
            bus.wr_en      = ($urandom_range(0, 5) == 0);
            bus.wr_addr    = 4'($urandom_range(0, 15));
            bus.wr_data    = 24'($urandom);
            bus.fade_start = ($urandom_range(0, 60) == 0);
            bus.fade_dir   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 50) == 0) bus.flicker_en = ~bus.flicker_en;
            tick();
        end
        frame_start = 0; vblank = 0; bus.wr_en = 0; bus.fade_start = 0; bus.flicker_en = 0;

        // reset mid-fade at level 5 with a write pending
        pulse_reset();
        color_idx = 4'd12; bus.fade_dir = 0; bus.fade_start = 1;
        tick();
        bus.fade_start = 0;
        repeat (11) frame_pulse();
        chk("mid_lvl5", {vga_r, vga_g, vga_b}, 24'h4F4F4F);
        bus.wr_addr = 4'd3; bus.wr_data = 24'h000001; bus.wr_en = 1;
        tick();
        bus.wr_en = 0;
        chk("mid_pending", bus.wr_ready, 1'b0);
        chk("mid_busy", bus.fade_busy, 1'b1);
        #2;
        rst_n = 0;
        #1;
        chk("async_busy",  bus.fade_busy, 1'b0);
        chk("async_ready", bus.wr_ready, 1'b1);
        chk("async_vga",   {vga_r, vga_g, vga_b}, 24'h0);
        tick();
        rst_n = 1;
        color_idx = 4'd3; vblank = 1;
        tick();
        tick();
        vblank = 0;
        chk("rst_drop_write", {vga_r, vga_g, vga_b}, 24'h46615B);
        color_idx = 4'd12;
        tick();
        chk("rst_full_level", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
        color_idx = 4'd2;
        tick();
        chk("rst_pal_default", {vga_r, vga_g, vga_b}, 24'h2D4745);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/palette_ctrl.md
# palette_ctrl

Frame-synchronous controller for the 16-entry, 24-bit display palette, sitting between the sprite/tile renderer and the VGA outputs. It holds a host-writable palette register file and applies global fade-in/fade-out brightness scaling and candle flicker. Host palette writes are buffered and committed only during vertical blank, so no frame tears. The pixel lookup path is registered with a fixed one-cycle latency.

## Interface
- FRAME_DIV, 8: frames per flicker phase toggle (≥1).
- FADE_STEP, 1: brightness-level change per frame during a fade (1..16).
- Clk  in  1  system clock.
- Reset_n  in  1  reset, asynchronous and active-low.
- frame_start  in  1  one-cycle pulse once per frame, at start of vertical blank.
- vblank  in  1  high for the whole vertical blank interval.
- colorIdx  in  4  palette index of the current pixel.
- VGA_R, VGA_G, VGA_B  out  8 each  scaled output color, registered.
- wr_en  in  1  host palette write request.
- wr_addr  in  4  entry to write.
- wr_data  in  24  RGB value, R in [23:16], B in [7:0].
- wr_ready  out  1  write buffer empty; a write is accepted when wr_en & wr_ready.
- fade_start  in  1  one-cycle pulse starting a fade.
- fade_dir  in  1  0 = fade out to black, 1 = fade in to full brightness.
- fade_busy  out  1  a fade is in progress.
- fade_done  out  1  one-cycle pulse when a fade completes.
- flicker_en  in  1  enables candle flicker.

## Operation
- Register file pal[0..15], 24 bits per entry. Reset contents:
  - 0: FF0000
  - 1: 05121B
  - 2: 2D4745
  - 3: 46615B
  - 4: 082026
  - 5: 223A42
  - 6: 000000
  - 7: BDBFA0
  - 8: FE9802
  - 9: 9A9A9A
  - 10: 16252F
  - 11: D624C1
  - 12: FFFFFF
  - 13–15: FF0000
- Lookup: base = pal[colorIdx]. When flicker_en & phase = 1 and colorIdx = 8, base = pal[12].
- Scaling:
  - Per channel, out = (ch × level) >> 4; ch is 8 bits, level is 5 bits (0..16), product is 13 bits.
  - level = 16 passes the color unchanged; level = 0 gives black. No rounding.
- Flicker:
  - A frame counter (0..FRAME_DIV−1) increments on each frame_start.
  - On wrap it resets to 0 and phase toggles.
  - It runs regardless of flicker_en.
- Write buffer, one deep:
  - An accepted write latches addr/data and drops wr_ready.
  - The pending entry commits to pal on the first cycle with vblank = 1 and the buffer full. wr_ready returns high the following cycle.
  - A write accepted in a cycle where vblank = 1 commits in the next cycle if vblank is still 1.
- Fade FSM:
  - IDLE:
    - fade_start latches fade_dir and goes to FADING.
    - If level already equals the target (0 for out, 16 for in), go to DONE instead.
  - FADING:
    - On each frame_start, level moves by FADE_STEP toward the target, saturating at 0 or 16.
    - When the new level equals the target, go to DONE.
    - fade_start is ignored in this state.
  - DONE: assert fade_done for one cycle, then go to IDLE.
  - fade_busy = 1 in FADING and DONE.
- level persists after a fade; a fade-out leaves the screen black until a fade-in.

## Timing
- Reset values:
  - VGA_R/G/B = 0; level = 16; phase = 0; frame counter = 0.
  - FSM = IDLE; fade_busy = 0; fade_done = 0.
  - wr_ready = 1; buffer empty; pal holds the default contents.
- Reset asserted mid-fade or with a write pending:
  - The pending write is discarded.
  - All state returns to reset values immediately (asynchronous).
- Latency:
  - colorIdx at cycle N appears on VGA_* at cycle N+1.
  - A level change caused by frame_start at cycle N affects outputs from cycle N+2.
- A commit to pal at cycle N affects lookups sampled at cycle N+1 or later.
- fade_start coinciding with frame_start in IDLE: no level step that frame; the first step is at the next frame_start.
- A fade-out from level 16 with FADE_STEP = 1 takes 16 frame_start pulses. fade_done pulses the cycle after the 16th.
- wr_en while wr_ready = 0 is ignored with no side effects.

## Test plan
- Reset, sweep colorIdx 0..15 → VGA matches the default table one cycle later (e.g. idx 11 → D6,24,C1); idx 13 → FF,00,00.
- Write 123456 to entry 2 with vblank = 0 → wr_ready drops; idx 2 still reads 2D4745. Raise vblank → commit. Idx 2 reads 12,34,56 and wr_ready returns to 1. A second wr_en while pending is ignored.
- fade_dir = 0, fade_start, then 8 frame_starts with FADE_STEP = 1 → level 8; idx 12 gives 7F,7F,7F. After 16 frame_starts total → fade_done pulses once and idx 12 gives 00,00,00.
- fade_start (in) at level 16 → fade_done one cycle later with no frames elapsed; a fade_start during FADING changes nothing.
- flicker_en = 1, FRAME_DIV = 2 → idx 8 reads FE9802 for 2 frames, then FFFFFF for 2 frames, alternating. With flicker_en = 0 it always reads FE9802.
- Deassert Reset_n mid-fade at level 5 with a write pending → level 16, fade_busy 0, wr_ready 1; the palette equals the defaults.
